// File: rtl/noc_credit_pkg.sv
// noc_credit_pkg: shared credit-width helpers and the per-VC lane match counter
package noc_credit_pkg;
    localparam int MAX_LANES = 32;
    localparam int MAX_IDW   = 8;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // wide enough for q + FREE_PORT_NUM - 1 without wrapping
    function automatic int sum_w(input int depth, input int lanes);
        return $clog2(depth + 1) + $clog2(lanes + 1) + 1;
    endfunction

    function automatic int popcount_match(
        input logic [MAX_LANES-1:0]         vld,
        input logic [MAX_LANES*MAX_IDW-1:0] ids,
        input int                           lanes,
        input int                           idw,
        input int                           vc
    );
        int n;
        int id;
        n = 0;
        for (int k = 0; k < lanes; k++) begin
            id = 0;
            for (int j = 0; j < idw; j++) id[j] = ids[k*idw+j];
            if (vld[k] && id == vc) n++;
        end
        return n;
    endfunction
endpackage

// File: rtl/std_dffrve.sv
// std_dffrve: enabled register with asynchronous active-low reset to RST_VAL
module std_dffrve #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/vc_credit_slot.sv
// vc_credit_slot: one VC's saturating credit counter with error pulses and flags
module vc_credit_slot
    import noc_credit_pkg::*;
#(
    parameter int VC_DEPTH      = 4,
    parameter int FREE_PORT_NUM = 2,
    parameter int CW            = cnt_w(VC_DEPTH),
    parameter int FCW           = $clog2(FREE_PORT_NUM + 1)
)(
    input  logic           clk,
    input  logic           rstn,
    input  logic [FCW-1:0] free_cnt,
    input  logic           cons,
    output logic [CW-1:0]  cnt,
    output logic           avail,
    output logic           full,
    output logic           ovf,
    output logic           udf
);
    localparam int SW = sum_w(VC_DEPTH, FREE_PORT_NUM);

    logic [SW-1:0] up, sum;
    logic [CW-1:0] nxt;

    // underflow is tested first: its wrapped sum would otherwise look like overflow
    always_comb begin
        up  = SW'(cnt) + SW'(free_cnt);
        sum = up - SW'(cons);
        udf = (up == '0) && cons;
        ovf = !udf && (sum > SW'(VC_DEPTH));
        nxt = udf ? '0 : ovf ? CW'(VC_DEPTH) : sum[CW-1:0];
    end

    std_dffrve #(.WIDTH(CW), .RST_VAL(CW'(VC_DEPTH))) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (nxt != cnt),
        .d    (nxt),
        .q    (cnt)
    );

    assign avail = cnt != '0;
    assign full  = cnt == CW'(VC_DEPTH);
endmodule

// File: rtl/output_port_vc_credit_manager.sv
// output_port_vc_credit_manager: per-VC credit tracking for one output port,
// multi-lane credit return, sticky overflow/underflow reporting.
module output_port_vc_credit_manager
    import noc_credit_pkg::*;
#(
    parameter int VC_NUM             = 4,
    parameter int VC_NUM_IDX_W       = (VC_NUM > 1 ? $clog2(VC_NUM) : 1),
    parameter int VC_DEPTH           = 4,
    parameter int VC_DEPTH_COUNTER_W = cnt_w(VC_DEPTH),
    parameter int FREE_PORT_NUM      = 2
)(
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [FREE_PORT_NUM-1:0]             free_vc_credit_vld_i,
    input  logic [FREE_PORT_NUM*VC_NUM_IDX_W-1:0] free_vc_credit_vc_id_i,
    input  logic                                 consume_vc_credit_vld_i,
    input  logic [VC_NUM_IDX_W-1:0]              consume_vc_credit_vc_id_i,
    input  logic                                 err_clr_i,
    output logic [VC_NUM*VC_DEPTH_COUNTER_W-1:0] vc_credit_counter_o,
    output logic [VC_NUM-1:0]                    vc_credit_avail_o,
    output logic [VC_NUM-1:0]                    vc_credit_full_o,
    output logic                                 credit_ovf_err_o,
    output logic                                 credit_udf_err_o,
    output logic [VC_NUM-1:0]                    credit_err_vc_o
);
    localparam int FCW = $clog2(FREE_PORT_NUM + 1);
    localparam int CW  = VC_DEPTH_COUNTER_W;

    logic [VC_NUM-1:0] ovf, udf;

    for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
        logic [FCW-1:0] free_cnt;
        logic           cons;
        assign free_cnt = FCW'(popcount_match(MAX_LANES'(free_vc_credit_vld_i),
                                              (MAX_LANES*MAX_IDW)'(free_vc_credit_vc_id_i),
                                              FREE_PORT_NUM, VC_NUM_IDX_W, i));
        assign cons = consume_vc_credit_vld_i && consume_vc_credit_vc_id_i == VC_NUM_IDX_W'(i);
        vc_credit_slot #(.VC_DEPTH(VC_DEPTH), .FREE_PORT_NUM(FREE_PORT_NUM), .CW(CW), .FCW(FCW)) u_slot (
            .clk      (clk),
            .rstn     (rstn),
            .free_cnt (free_cnt),
            .cons     (cons),
            .cnt      (vc_credit_counter_o[i*CW +: CW]),
            .avail    (vc_credit_avail_o[i]),
            .full     (vc_credit_full_o[i]),
            .ovf      (ovf[i]),
            .udf      (udf[i])
        );
    end

    // a clear and a fresh error in the same cycle: the fresh error survives
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            credit_ovf_err_o <= 1'b0;
            credit_udf_err_o <= 1'b0;
            credit_err_vc_o  <= '0;
        end else begin
            credit_ovf_err_o <= (credit_ovf_err_o && !err_clr_i) || |ovf;
            credit_udf_err_o <= (credit_udf_err_o && !err_clr_i) || |udf;
            credit_err_vc_o  <= (credit_err_vc_o & {VC_NUM{!err_clr_i}}) | ovf | udf;
        end
endmodule

// File: tb/tb_output_port_vc_credit_manager.sv
// tb_output_port_vc_credit_manager: directed vector table, multi-cycle sequences
// and a randomised burst with an asynchronous reset checked against a model.
module tb_output_port_vc_credit_manager;
    localparam int VN = 4, IW = 2, D = 4, CW = 3, FP = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [FP-1:0]     fv = '0;
    logic [FP*IW-1:0]  fid = '0;
    logic              cv = 1'b0;
    logic [IW-1:0]     cid = '0;
    logic              clr = 1'b0;
    logic [VN*CW-1:0]  cnt;
    logic [VN-1:0]     av, fu, ev;
    logic              ovf, udf;

    int nchk = 0, nerr = 0;

    output_port_vc_credit_manager #(
        .VC_NUM(VN), .VC_NUM_IDX_W(IW), .VC_DEPTH(D), .VC_DEPTH_COUNTER_W(CW), .FREE_PORT_NUM(FP)
    ) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .free_vc_credit_vld_i      (fv),
        .free_vc_credit_vc_id_i    (fid),
        .consume_vc_credit_vld_i   (cv),
        .consume_vc_credit_vc_id_i (cid),
        .err_clr_i                 (clr),
        .vc_credit_counter_o       (cnt),
        .vc_credit_avail_o         (av),
        .vc_credit_full_o          (fu),
        .credit_ovf_err_o          (ovf),
        .credit_udf_err_o          (udf),
        .credit_err_vc_o           (ev)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fv;
        logic [3:0]  fid;
        logic        cv;
        logic [1:0]  cid;
        logic        clr;
        int          reps;
        logic [11:0] cnt;
        logic [3:0]  av, fu;
        logic        ovf, udf;
        logic [3:0]  ev;
    } vec_t;

    vec_t v[25];

    function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
        return {c3[2:0], c2[2:0], c1[2:0], c0[2:0]};
    endfunction

    function automatic vec_t mk(input logic [1:0] f, input logic [3:0] id, input logic c,
                                input logic [1:0] ci, input logic cl, input int r,
                                input logic [11:0] n, input logic [3:0] a, input logic [3:0] u,
                                input logic o, input logic d, input logic [3:0] e);
        vec_t x;
        x.fv = f; x.fid = id; x.cv = c; x.cid = ci; x.clr = cl; x.reps = r;
        x.cnt = n; x.av = a; x.fu = u; x.ovf = o; x.udf = d; x.ev = e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [11:0] n, input logic [3:0] a,
                           input logic [3:0] u, input logic o, input logic d, input logic [3:0] e);
        chk({tag, ".cnt"}, 32'(cnt), 32'(n));
        chk({tag, ".avail"}, 32'(av), 32'(a));
        chk({tag, ".full"}, 32'(fu), 32'(u));
        chk({tag, ".ovf"}, 32'(ovf), 32'(o));
        chk({tag, ".udf"}, 32'(udf), 32'(d));
        chk({tag, ".err_vc"}, 32'(ev), 32'(e));
    endtask

    int         m[VN];
    bit         mo, mu;
    bit [VN-1:0] mev;

    task automatic model_reset();
        for (int i = 0; i < VN; i++) m[i] = D;
        mo = 0; mu = 0; mev = '0;
    endtask

    task automatic model_step(input logic [1:0] f, input logic [3:0] id, input logic c,
                              input logic [1:0] ci, input logic cl);
        bit [VN-1:0] no, nu;
        int nf, up, cc;
        no = '0; nu = '0;
        for (int i = 0; i < VN; i++) begin
            nf = 0;
            for (int k = 0; k < FP; k++) if (f[k] && id[k*IW +: IW] == i) nf++;
            cc = (c && ci == i) ? 1 : 0;
            up = m[i] + nf;
            if (up == 0 && cc == 1) nu[i] = 1'b1;
            else if (up - cc > D) begin m[i] = D; no[i] = 1'b1; end
            else m[i] = up - cc;
        end
        if (cl) begin mo = 0; mu = 0; mev = '0; end
        mo = mo | (|no);
        mu = mu | (|nu);
        mev = mev | no | nu;
    endtask

    task automatic chk_model(input string tag);
        logic [11:0] n;
        logic [3:0]  a, u;
        for (int i = 0; i < VN; i++) begin
            n[i*CW +: CW] = 3'(m[i]);
            a[i] = m[i] != 0;
            u[i] = m[i] == D;
        end
        chk_all(tag, n, a, u, mo, mu, mev);
    endtask

    initial begin
        v[0]  = mk(0, 4'b0000, 0, 0, 0, 1,  pk(4,4,4,4), 4'b1111, 4'b1111, 0, 0, 4'b0000);
        v[1]  = mk(0, 4'b0000, 1, 2, 0, 1,  pk(4,3,4,4), 4'b1111, 4'b1011, 0, 0, 4'b0000);
        v[2]  = mk(0, 4'b0000, 1, 2, 0, 1,  pk(4,2,4,4), 4'b1111, 4'b1011, 0, 0, 4'b0000);
        v[3]  = mk(0, 4'b0000, 1, 2, 0, 1,  pk(4,1,4,4), 4'b1111, 4'b1011, 0, 0, 4'b0000);
        v[4]  = mk(0, 4'b0000, 1, 2, 0, 1,  pk(4,0,4,4), 4'b1011, 4'b1011, 0, 0, 4'b0000);
        v[5]  = mk(3, 4'b1010, 1, 2, 0, 1,  pk(4,1,4,4), 4'b1111, 4'b1011, 0, 0, 4'b0000);
        v[6]  = mk(0, 4'b0000, 1, 1, 0, 1,  pk(4,1,3,4), 4'b1111, 4'b1001, 0, 0, 4'b0000);
        v[7]  = mk(3, 4'b0101, 0, 0, 0, 1,  pk(4,1,4,4), 4'b1111, 4'b1011, 1, 0, 4'b0010);
        v[8]  = mk(0, 4'b0000, 0, 0, 0, 10, pk(4,1,4,4), 4'b1111, 4'b1011, 1, 0, 4'b0010);
        v[9]  = mk(0, 4'b0000, 0, 0, 1, 1,  pk(4,1,4,4), 4'b1111, 4'b1011, 0, 0, 4'b0000);
        v[10] = mk(0, 4'b0000, 1, 0, 0, 1,  pk(4,1,4,3), 4'b1111, 4'b1010, 0, 0, 4'b0000);
        v[11] = mk(0, 4'b0000, 1, 0, 0, 1,  pk(4,1,4,2), 4'b1111, 4'b1010, 0, 0, 4'b0000);
        v[12] = mk(0, 4'b0000, 1, 0, 0, 1,  pk(4,1,4,1), 4'b1111, 4'b1010, 0, 0, 4'b0000);
        v[13] = mk(0, 4'b0000, 1, 0, 0, 1,  pk(4,1,4,0), 4'b1110, 4'b1010, 0, 0, 4'b0000);
        v[14] = mk(0, 4'b0000, 1, 0, 0, 1,  pk(4,1,4,0), 4'b1110, 4'b1010, 0, 1, 4'b0001);
        v[15] = mk(0, 4'b0000, 1, 3, 0, 1,  pk(3,1,4,0), 4'b1110, 4'b0010, 0, 1, 4'b0001);
        v[16] = mk(0, 4'b0000, 1, 3, 0, 1,  pk(2,1,4,0), 4'b1110, 4'b0010, 0, 1, 4'b0001);
        v[17] = mk(0, 4'b0000, 1, 3, 0, 1,  pk(1,1,4,0), 4'b1110, 4'b0010, 0, 1, 4'b0001);
        v[18] = mk(0, 4'b0000, 1, 3, 0, 1,  pk(0,1,4,0), 4'b0110, 4'b0010, 0, 1, 4'b0001);
        v[19] = mk(0, 4'b0000, 1, 3, 1, 1,  pk(0,1,4,0), 4'b0110, 4'b0010, 0, 1, 4'b1000);
        v[20] = mk(0, 4'b0000, 0, 0, 1, 1,  pk(0,1,4,0), 4'b0110, 4'b0010, 0, 0, 4'b0000);
        v[21] = mk(2, 4'b0011, 0, 0, 0, 1,  pk(0,1,4,1), 4'b0111, 4'b0010, 0, 0, 4'b0000);
        v[22] = mk(3, 4'b0011, 0, 0, 0, 1,  pk(1,1,4,2), 4'b1111, 4'b0010, 0, 0, 4'b0000);
        v[23] = mk(3, 4'b1000, 1, 0, 0, 1,  pk(1,2,4,2), 4'b1111, 4'b0010, 0, 0, 4'b0000);
        v[24] = mk(1, 4'b0001, 0, 0, 0, 1,  pk(1,2,4,2), 4'b1111, 4'b0010, 1, 0, 4'b0010);

        repeat (2) @(posedge clk);
        #1 chk_all("reset", pk(4,4,4,4), 4'b1111, 4'b1111, 0, 0, 4'b0000);
        @(negedge clk) rstn = 1'b1;

        for (int r = 0; r < 25; r++) begin
            for (int p = 0; p < v[r].reps; p++) begin
                @(negedge clk);
                fv = v[r].fv; fid = v[r].fid; cv = v[r].cv; cid = v[r].cid; clr = v[r].clr;
                @(posedge clk);
                #1 chk_all($sformatf("vec%0d", r), v[r].cnt, v[r].av, v[r].fu, v[r].ovf, v[r].udf, v[r].ev);
            end
        end

        // randomised burst with an asynchronous reset landing between clock edges
        @(negedge clk);
        fv = '0; cv = 1'b0; clr = 1'b0;
        rstn = 1'b0;
        #1 model_reset();
        chk_model("rnd_rst0");
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            rstn = 1'b1;
            fv  = FP'($urandom_range(0, 3));
            fid = (FP*IW)'($urandom);
            cv  = ($urandom_range(0, 2) != 0);
            cid = IW'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            model_step(fv, fid, cv, cid, clr);
            #1 chk_model($sformatf("rnd%0d", c));
            if (c == 100) begin
                #2 rstn = 1'b0;
                #1 model_reset();
                chk_model("rnd_async_rst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/output_port_vc_credit_manager.md
# output_port_vc_credit_manager

Per-output-port credit tracker for the router's virtual channels. Generalised successor to the single-return credit counter, with these additions:
- up to FREE_PORT_NUM credit returns per cycle, against one consume per cycle;
- saturating arithmetic with sticky overflow/underflow error reporting;
- per-VC availability and full flags.

It sits between the output-port VC allocator (consume side) and the downstream credit-return links (free side).

## Interface
Parameters:
- VC_NUM, 4, number of virtual channels
- VC_NUM_IDX_W, (VC_NUM>1 ? $clog2(VC_NUM) : 1), VC id width
- VC_DEPTH, 4, downstream buffer depth per VC, which is also the reset credit count
- VC_DEPTH_COUNTER_W, $clog2(VC_DEPTH+1), per-VC counter width
- FREE_PORT_NUM, 2, number of credit-return lanes per cycle (≥1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous assert, active-low
- free_vc_credit_vld_i  in  FREE_PORT_NUM  per-lane credit-return valid
- free_vc_credit_vc_id_i  in  FREE_PORT_NUM*VC_NUM_IDX_W  per-lane VC id; lane k occupies bits [k*VC_NUM_IDX_W +: VC_NUM_IDX_W]
- consume_vc_credit_vld_i  in  1  credit consumed (flit sent)
- consume_vc_credit_vc_id_i  in  VC_NUM_IDX_W  VC of the consumed credit
- err_clr_i  in  1  clears the sticky error state
- vc_credit_counter_o  out  VC_NUM*VC_DEPTH_COUNTER_W  per-VC credit count; VC i occupies bits [i*W +: W]
- vc_credit_avail_o  out  VC_NUM  VC i count != 0
- vc_credit_full_o  out  VC_NUM  VC i count == VC_DEPTH (downstream empty)
- credit_ovf_err_o  out  1  sticky overflow error
- credit_udf_err_o  out  1  sticky underflow error
- credit_err_vc_o  out  VC_NUM  sticky mask of VCs that raised either error

## Operation
- Per VC i, each cycle:
  - free_cnt[i] = number of lanes k with vld[k] and id[k] == i (0..FREE_PORT_NUM).
  - cons[i] = consume_vld and consume_id == i.
- Several lanes carrying the same VC in one cycle is legal; each lane counts as one credit.
- The sum is formed at width VC_DEPTH_COUNTER_W + $clog2(FREE_PORT_NUM+1) + 1 so that it cannot wrap: sum = q + free_cnt − cons.
- Next-state rules:
  - sum > VC_DEPTH: next = VC_DEPTH; set overflow error and credit_err_vc[i].
  - q + free_cnt == 0 and cons: next = 0 (hold); set underflow error and credit_err_vc[i].
  - otherwise: next = sum.
- A consume at q == 0 together with one free to the same VC is legal: net zero, no error.
- A VC's register is enabled only when next != q.
- Sticky errors:
  - They hold until err_clr_i.
  - If a clear and a new error occur in the same cycle, the set wins for the newly erring bits; all other bits clear.
- Out-of-range VC ids (≥ VC_NUM) hit nothing and are silently ignored.
- vc_credit_avail_o and vc_credit_full_o are decoded combinationally from the registered counts only; there is no input-to-output combinational path.

## Timing
- Reset (rstn low, asynchronous):
  - every counter = VC_DEPTH;
  - vc_credit_avail_o = all ones;
  - vc_credit_full_o = all ones;
  - all error outputs = 0.
- Update latency is 1 cycle: events sampled at posedge N are visible on all outputs after posedge N.
- Error flags assert in the same cycle as the counter update that caused them.
- Reset asserted mid-operation discards any in-flight events; the first edge after rstn deasserts operates from the reset state.
- There is no handshake: the caller must not consume a VC whose vc_credit_avail_o is 0. Doing so is reported as underflow, not blocked.

## Structure
- Shared router package noc_credit_pkg holds:
  - a constant function for the counter/sum widths;
  - a constant function popcount_match(vld, ids, vc) used by every credit block.
- Registers: one std_dffrve (WIDTH = VC_DEPTH_COUNTER_W, rst_val = VC_DEPTH) per VC; plain flops for the error state.
- One natural sub-module, vc_credit_slot: one VC's counter, its saturation/error logic and its flags. Instantiate VC_NUM times in a generate loop; the top level does id decode and error OR-reduction.

## Test plan
- Reset, VC_NUM=4, VC_DEPTH=4 → counters all 4, avail=4'b1111, full=4'b1111, errors 0.
- Four consumes on VC2 on consecutive cycles → counts 3,2,1,0; avail[2] falls after the 4th edge; full[2] falls after the 1st edge.
- From VC2=0: both free lanes on VC2 plus a consume on VC2 in the same cycle → VC2=1, no error.
- VC1=3: two free lanes on VC1 → VC1 saturates at 4, credit_ovf_err_o=1, credit_err_vc_o=4'b0010; the flags stay set over 10 idle cycles; after err_clr_i they read 0.
- VC0=0: consume VC0 with no free → VC0 stays 0, credit_udf_err_o=1. In the same cycle as err_clr_i, a VC3 underflow → credit_err_vc_o=4'b1000 and udf stays set.
- Random consume/free traffic with rstn pulsed mid-burst → all counts return to 4 asynchronously; the scoreboard model matches every cycle thereafter.
